input_conditioner: RTL and testbench

//   Parametrised front end for all board push-buttons/switches: synchronises raw pins,

---
 rtl/input_cond_pkg.sv | 19 +
 rtl/input_conditioner_channel.sv | 122 ++++++++++++
 rtl/input_conditioner.sv | 39 +++
 tb/tb_input_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and default timing for the push-button/switch input conditioner.
package input_cond_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Defaults for a 40 MHz system clock.
  localparam int DEBOUNCE_10MS      = 400000;
  localparam int REPEAT_DELAY_500MS = 20000000;
  localparam int REPEAT_RATE_100MS  = 4000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One input channel: synchroniser chain, debounce counter and hold-to-repeat FSM.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_RATE     = REPEAT_RATE_100MS,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk_40MHz,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE));

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;
  logic                   commit;
  logic                   rise_ev;
  logic                   fall_ev;
  rpt_state_t             state;
  rpt_state_t             state_next;
  logic [RPT_W-1:0]       rep_cnt;
  logic [RPT_W-1:0]       rep_cnt_next;
  logic                   repeat_ev;

  assign sync    = sync_chain[SYNC_STAGES-1];
  assign commit  = (sync != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise_ev = commit & sync;
  assign fall_ev = commit & ~sync;

  always_ff @(posedge clk_40MHz or posedge reset) begin
    if (reset) sync_chain <= '0;
    else       sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
  end

  // Level only follows sync after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_40MHz or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_ev;
      fall_pulse <= fall_ev;
      if (sync == level) begin
        cnt <= '0;
      end else if (commit) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_40MHz or posedge reset) begin
    if (reset) begin
      state       <= RPT_IDLE;
      rep_cnt     <= '0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      rep_cnt     <= rep_cnt_next;
      press_pulse <= rise_ev | repeat_ev;
    end
  end

  // The FSM keys off the debounce commit itself so the first repeat lands
  // exactly REPEAT_DELAY cycles after the rise pulse; a fall beats a due repeat.
  always_comb begin
    state_next   = state;
    rep_cnt_next = rep_cnt;
    repeat_ev    = 1'b0;
    if (!REPEAT_EN || fall_ev) begin
      state_next   = RPT_IDLE;
      rep_cnt_next = '0;
    end else begin
      case (state)
        RPT_IDLE: begin
          if (rise_ev) begin
            state_next   = RPT_DELAY;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = '0;
          end
        end
        RPT_DELAY: begin
          if (rep_cnt == RPT_W'(REPEAT_DELAY - 1)) begin
            state_next   = RPT_REPEAT;
            rep_cnt_next = '0;
            repeat_ev    = 1'b1;
          end else begin
            rep_cnt_next = rep_cnt + RPT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (rep_cnt == RPT_W'(REPEAT_RATE - 1)) begin
            rep_cnt_next = '0;
            repeat_ev    = 1'b1;
          end else begin
            rep_cnt_next = rep_cnt + RPT_W'(1);
          end
        end
        default: begin
          state_next   = RPT_IDLE;
          rep_cnt_next = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Front end for board buttons/switches: N_CH independent synchronise/debounce/repeat channels.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int              N_CH            = 4,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int              REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int              REPEAT_RATE     = REPEAT_RATE_100MS,
  parameter logic [N_CH-1:0] REPEAT_MASK     = 4'b0110
) (
  input  logic            clk_40MHz,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] press_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .clk_40MHz  (clk_40MHz),
      .reset      (reset),
      .raw        (raw_in[i]),
      .level      (level[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .press_pulse(press_pulse[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed checks of input_conditioner against an event-timing reference model.
module tb_input_conditioner;

  localparam int N = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam logic [3:0] MASK = 4'b0110;

  logic       clk_40MHz = 1'b0;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] level, rise_pulse, fall_pulse, press_pulse;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [SS-1:0] pipe [N];
  int            run [N];
  logic          lvl [N];
  int            t_rise [N];
  int            t_now;
  logic [3:0]    exp_level, exp_rise, exp_fall, exp_press;

  input_conditioner #(
    .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk_40MHz  (clk_40MHz),
    .reset      (reset),
    .raw_in     (raw_in),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .press_pulse(press_pulse)
  );

  always #12.5 clk_40MHz = ~clk_40MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      pipe[c] = '0; run[c] = 0; lvl[c] = 1'b0; t_rise[c] = 0;
    end
    t_now = 0;
    exp_level = '0; exp_rise = '0; exp_fall = '0; exp_press = '0;
  endtask

  // Level flips after DB consecutive synced samples disagree with it; repeats fall
  // at rise+RD, rise+RD+RR, ... while the level stays high on masked channels.
  task automatic model_edge(input logic [3:0] r);
    logic s;
    t_now++;
    for (int c = 0; c < N; c++) begin
      s = pipe[c][SS-1];
      pipe[c] = {pipe[c][SS-2:0], r[c]};
      exp_rise[c] = 1'b0;
      exp_fall[c] = 1'b0;
      if (s != lvl[c]) begin
        run[c]++;
        if (run[c] == DB) begin
          lvl[c] = s;
          run[c] = 0;
          exp_rise[c] = s;
          exp_fall[c] = ~s;
          if (s) t_rise[c] = t_now;
        end
      end else begin
        run[c] = 0;
      end
      exp_level[c] = lvl[c];
      exp_press[c] = exp_rise[c] |
                     (MASK[c] && lvl[c] && (t_now - t_rise[c] >= RD) &&
                      ((t_now - t_rise[c] - RD) % RR == 0));
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".level"}, 32'(level),       32'(exp_level));
    check({ph, ".rise"},  32'(rise_pulse),  32'(exp_rise));
    check({ph, ".fall"},  32'(fall_pulse),  32'(exp_fall));
    check({ph, ".press"}, 32'(press_pulse), 32'(exp_press));
  endtask

  // called at a negedge: drive, clock, update model, compare at next negedge
  task automatic step(input logic [3:0] r, input string ph);
    raw_in = r;
    @(posedge clk_40MHz);
    if (reset) model_reset();
    else       model_edge(r);
    @(negedge clk_40MHz);
    compare_all(ph);
  endtask

  task automatic pulse_reset(input string ph);
    reset = 1'b1;
    model_reset();
    #1;
    compare_all({ph, ".rst_now"});
    @(negedge clk_40MHz);
    step(raw_in, ph);
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) step(4'b0000, ph);
  endtask

  initial begin
    logic [3:0] r;
    reset  = 1'b1;
    raw_in = 4'b0000;
    model_reset();
    @(negedge clk_40MHz);
    @(negedge clk_40MHz);
    compare_all("reset");
    reset = 1'b0;

    // 1: single non-repeating channel
    for (int i = 1; i <= 20; i++) begin
      step(4'b0001, "t1");
      if (i == 6) check("t1.rise_at6", 32'(rise_pulse[0]), 32'd1);
      if (i == 5) check("t1.level_before6", 32'(level[0]), 32'd0);
    end
    idle(12, "t1r");

    // 2: glitch shorter than debounce window
    for (int i = 0; i < 3; i++) step(4'b0010, "t2");
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, "t2");
      if (i == 6) check("t2.level1", 32'(level[1]), 32'd0);
    end

    // 3: hold-to-repeat then release
    for (int i = 1; i <= 40; i++) begin
      step(4'b0010, "t3");
      if (i == 6 || i == 16 || i == 19 || i == 22 || i == 25)
        check("t3.press1", 32'(press_pulse[1]), 32'd1);
    end
    for (int i = 1; i <= 12; i++) begin
      step(4'b0000, "t3r");
      if (i == 6) check("t3.fall1", 32'(fall_pulse[1]), 32'd1);
    end

    // 4: release timed so the fall lands on the edge a repeat is due (rise+13)
    for (int i = 1; i <= 13; i++) begin
      step(4'b0100, "t4");
      if (i == 16 - 3) check("t4.hold", 32'(level[2]), 32'd1);
    end
    for (int i = 14; i <= 26; i++) begin
      step(4'b0000, "t4");
      if (i == 16) check("t4.rep16", 32'(press_pulse[2]), 32'd1);
      if (i == 19) begin
        check("t4.fall19", 32'(fall_pulse[2]), 32'd1);
        check("t4.nopress19", 32'(press_pulse[2]), 32'd0);
      end
    end

    // 5: all channels together
    for (int i = 1; i <= 8; i++) begin
      step(4'b1111, "t5");
      if (i == 6) check("t5.rise_all", 32'(rise_pulse), 32'hf);
    end
    idle(10, "t5r");

    // 6: reset in the middle of repeating
    for (int i = 0; i < 20; i++) step(4'b0010, "t6");
    pulse_reset("t6");
    for (int i = 1; i <= 20; i++) begin
      step(4'b0010, "t6a");
      if (i == 6)  check("t6.rise", 32'(rise_pulse[1]), 32'd1);
      if (i == 16) check("t6.rep", 32'(press_pulse[1]), 32'd1);
    end
    idle(12, "t6r");

    // randomised: slowly-toggling channels with occasional short glitches
    r = 4'b0000;
    for (int i = 0; i < 1200; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 9) == 0) r[c] = ~r[c];
      if (i == 600) pulse_reset("rnd");
      step(r, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
